frb_square_picker: RTL

Input-side counterpart of the FRB square row overlay: where the renderer maps the scanned pixel to a square index, this block maps the player's aim point and trigger to a selected square. It sits between the crosshair/trigger input logic and the game controller. It synchronises and debounces the raw trigger key, hit-tests the aim point against the three 32×32 FRB squares, and emits a one-cycle pick pulse with the square index. It also keeps a sticky selection and a per-cycle hover indication for highlight rendering.

---
 rtl/frb_square_picker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/frb_square_picker.sv
// Maps the player's aim point and debounced trigger to a pick of one of the three
// 32x32 FRB squares. Also provides a registered hover indication and a sticky selection.
module frb_square_picker #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COOLDOWN_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] aim_x,
    input  logic [9:0] aim_y,
    input  logic       trigger_n,
    output logic       hover,
    output logic [1:0] hover_index,
    output logic       pick_valid,
    output logic [1:0] pick_index,
    output logic [1:0] selected_index,
    output logic       busy
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ? DEBOUNCE_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_DEBOUNCE     = 3'd1;
    localparam logic [2:0] S_EVAL         = 3'd2;
    localparam logic [2:0] S_COOLDOWN     = 3'd3;
    localparam logic [2:0] S_WAIT_RELEASE = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hover;
    logic [1:0]       r_hover_index;
    logic             r_pick_valid;
    logic [1:0]       r_pick_index;
    logic [1:0]       r_selected_index;

    logic             w_trig_s;
    logic             w_hit;
    logic [9:0]       w_off;
    logic [1:0]       w_idx;

    assign w_trig_s = ~r_sync2;

    // Square row spans x 161..256, y 415..446; each square is 32 px wide.
    assign w_hit = (aim_x >= 10'd161) && (aim_x <= 10'd256) &&
                   (aim_y >= 10'd415) && (aim_y <= 10'd446);
    assign w_off = w_hit ? (aim_x - 10'd161) : 10'd0;
    assign w_idx = 2'(w_off >> 5);

    // Two-stage synchroniser for the asynchronous trigger; both stages idle released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= trigger_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_WAIT_RELEASE;
            r_cnt            <= '0;
            r_hover          <= 1'b0;
            r_hover_index    <= 2'd0;
            r_pick_valid     <= 1'b0;
            r_pick_index     <= 2'd0;
            r_selected_index <= 2'd0;
        end else begin
            r_hover       <= w_hit;
            r_hover_index <= w_idx;
            r_pick_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trig_s) begin
                        r_state <= S_DEBOUNCE;
                        r_cnt   <= '0;
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_trig_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= S_EVAL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    r_cnt <= '0;
                    if (w_hit) begin
                        r_pick_valid     <= 1'b1;
                        r_pick_index     <= w_idx;
                        r_selected_index <= w_idx;
                        r_state          <= S_COOLDOWN;
                    end else begin
                        r_state <= S_WAIT_RELEASE;
                    end
                end
                S_COOLDOWN: begin
                    if (r_cnt == COOL_LAST) begin
                        r_state <= S_WAIT_RELEASE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_RELEASE: begin
                    // Any pressed sample restarts the release window.
                    if (w_trig_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_WAIT_RELEASE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign hover          = r_hover;
    assign hover_index    = r_hover_index;
    assign pick_valid     = r_pick_valid;
    assign pick_index     = r_pick_index;
    assign selected_index = r_selected_index;
    assign busy           = (r_state != S_IDLE);

endmodule
